// File: rtl/uart_pkg.sv
// Shared FSM encoding and default constants for the UART transmit arbiter.
package uart_pkg;

  localparam int DEF_BITS    = 8;
  localparam int DEF_N       = 4;
  localparam int DEF_GAP     = 2;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } state_t;

  // One counter serves both the SEND timeout and the GAP interval.
  function automatic int cnt_width(input int timeout, input int gap);
    int m;
    m = (timeout > gap) ? timeout : gap;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the requester just after last_grant has
// top priority, then the search continues upward with wrap-around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          any_req
);

  logic [GW-1:0] w_idx;

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    w_idx = '0;
    // Walk from lowest priority to highest so the highest-priority hit is written last.
    for (int i = N; i >= 1; i--) begin
      w_idx = GW'((int'(last_grant) + i) % N);
      if (req[w_idx]) grant = w_idx;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N word requesters into one UART transmitter,
// with an inter-frame gap and a SEND watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int BITS    = DEF_BITS,
  parameter int N       = DEF_N,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*BITS-1:0]    req_data,
  output logic [N-1:0]         ack,
  output logic [BITS-1:0]      tx_data,
  output logic                 tx_data_ready,
  input  logic                 tx_data_sent,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout_err
);

  localparam int GW = $clog2(N);
  localparam int CW = cnt_width(TIMEOUT, GAP);
  localparam logic [CW-1:0] SEND_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam state_t        AFTER_SEND = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_t          r_state;
  logic [N-1:0]    r_ack;
  logic [BITS-1:0] r_tx_data;
  logic            r_tx_data_ready;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_last_grant;
  logic            r_timeout_err;
  logic [CW-1:0]   r_cnt;

  logic [BITS-1:0] w_words [N];
  logic [GW-1:0]   w_grant;
  logic            w_any_req;

  for (genvar g = 0; g < N; g++) begin : g_words
    assign w_words[g] = req_data[g*BITS +: BITS];
  end

  rr_arbiter #(.N(N), .GW(GW)) u_rr (
    .req        (req),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .any_req    (w_any_req)
  );

  // The winner is captured on the IDLE->LOAD edge, so ack, grant_id and
  // tx_data are all presented during the LOAD cycle itself.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_ack           <= '0;
      r_tx_data       <= '0;
      r_tx_data_ready <= 1'b0;
      r_grant_id      <= '0;
      r_last_grant    <= GW'(N - 1);
      r_timeout_err   <= 1'b0;
      r_cnt           <= '0;
    end else begin
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state      <= ST_LOAD;
            r_ack        <= N'(1) << w_grant;
            r_grant_id   <= w_grant;
            r_last_grant <= w_grant;
            r_tx_data    <= w_words[w_grant];
          end
        end
        ST_LOAD: begin
          r_state         <= ST_SEND;
          r_tx_data_ready <= 1'b1;
          r_cnt           <= '0;
        end
        ST_SEND: begin
          // A completion on the last allowed clock still counts as success.
          if (tx_data_sent) begin
            r_state         <= AFTER_SEND;
            r_tx_data_ready <= 1'b0;
            r_cnt           <= '0;
          end else if (r_cnt == SEND_LAST) begin
            r_state         <= AFTER_SEND;
            r_tx_data_ready <= 1'b0;
            r_timeout_err   <= 1'b1;
            r_cnt           <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack           = r_ack;
  assign tx_data       = r_tx_data;
  assign tx_data_ready = r_tx_data_ready;
  assign grant_id      = r_grant_id;
  assign timeout_err   = r_timeout_err;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester agents, a transmitter model,
// and a round-robin reference model predicting ack order and frame contents.
module tb_uart_tx_arbiter;

  localparam int BITS    = 8;
  localparam int N       = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N*BITS-1:0]    req_data;
  logic [N-1:0]         ack;
  logic [BITS-1:0]      tx_data;
  logic                 tx_data_ready;
  logic                 tx_data_sent;
  logic                 busy;
  logic [$clog2(N)-1:0] grant_id;
  logic                 timeout_err;

  logic model_sent = 1'b0;
  logic stray      = 1'b0;
  logic tx_mute    = 1'b0;
  assign tx_data_sent = model_sent | stray;

  uart_tx_arbiter #(.BITS(BITS), .N(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .tx_data_sent  (tx_data_sent),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t exp_ack_q [$];
  int   exp_frame_q [$];
  int   ack_log [$];

  int n_tests = 0;
  int n_fail  = 0;
  int model_last = N - 1;

  logic [BITS-1:0] words [N][8];
  int cnt  [N];
  int sent [N];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Requester agents: hold req with the current word until acked, then move on.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ack[i]) sent[i]++;
      req[i] = (sent[i] < cnt[i]);
      if (sent[i] < cnt[i]) req_data[i*BITS +: BITS] = words[i][sent[i]];
    end
  end

  // Transmitter model: completes each frame after a random 0..4 clock delay.
  int   tx_wait = 0;
  logic tx_prev = 1'b0;
  always @(negedge clk) begin
    model_sent = 1'b0;
    if (tx_data_ready && !tx_prev) tx_wait = int'($urandom_range(0, 4));
    if (tx_data_ready && !tx_mute) begin
      if (tx_wait == 0) model_sent = 1'b1;
      else tx_wait--;
    end
    tx_prev = tx_data_ready;
  end

  // Monitor: pops the scoreboard whenever the DUT acks or starts a frame.
  logic prev_ready = 1'b0;
  int   cur_frame  = 0;
  int   mon_id;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (ack != '0) begin
        mon_id = -1;
        for (int i = 0; i < N; i++) if (ack[i]) mon_id = i;
        check("ack_onehot", $countones(ack), 1);
        ack_log.push_back(mon_id);
        if (exp_ack_q.size() == 0) begin
          check("ack_unexpected", $countones(ack), 0);
        end else begin
          mon_e = exp_ack_q.pop_front();
          check("ack_id", mon_id, mon_e.id);
          check("load_tx_data", int'(tx_data), mon_e.data);
          check("load_grant_id", int'(grant_id), mon_e.id);
          check("load_ready_low", int'(tx_data_ready), 0);
        end
      end
      if (tx_data_ready && !prev_ready) begin
        if (exp_frame_q.size() == 0) begin
          check("frame_unexpected", int'(tx_data_ready), 0);
        end else begin
          cur_frame = exp_frame_q.pop_front();
          check("frame_data", int'(tx_data), cur_frame);
        end
      end else if (tx_data_ready) begin
        check("send_stable", int'(tx_data), cur_frame);
      end
      prev_ready = tx_data_ready;
    end
  end

  // Reference model: serve every pending word, always choosing the nearest
  // requester after the previous winner (cyclically) that still has words left.
  task automatic model_expect();
    int rem [N];
    int k [N];
    int total;
    int c;
    total = 0;
    c = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = cnt[i];
      k[i]   = 0;
      total += cnt[i];
    end
    for (int t = 0; t < total; t++) begin
      for (int off = 1; off <= N; off++) begin
        c = (model_last + off) % N;
        if (rem[c] > 0) break;
      end
      rem[c]--;
      exp_ack_q.push_back('{c, int'(words[c][k[c]])});
      exp_frame_q.push_back(int'(words[c][k[c]]));
      k[c]++;
      model_last = c;
    end
  endtask

  task automatic start_batch();
    for (int i = 0; i < N; i++) sent[i] = 0;
    model_expect();
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (exp_ack_q.size() == 0 && exp_frame_q.size() == 0 && !busy) break;
    end
    check("drain_ack_q", exp_ack_q.size(), 0);
    check("drain_frame_q", exp_frame_q.size(), 0);
    check("drain_idle", int'(busy), 0);
  endtask

  task automatic wait_ready(input logic level);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (tx_data_ready == level) break;
    end
  endtask

  int n_send;
  logic saw_act;
  int exp035 [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 0;
      sent[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", int'(ack), 0);
    check("rst_ready", int'(tx_data_ready), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Four requesters held high: requester 0 has two words, so it comes round again.
    ack_log.delete();
    for (int i = 0; i < N; i++) begin
      words[i][0] = 8'hA0 + 8'(i);
      words[i][1] = 8'hA0 + 8'(i);
      cnt[i] = 1;
    end
    cnt[0] = 2;
    start_batch();
    wait_drain();
    check("rr4_ack_count", ack_log.size(), 5);
    if (ack_log.size() == 5)
      for (int k = 0; k < 5; k++) check("rr4_ack_order", ack_log[k], exp035[k]);

    // Single requester: ack in LOAD, tx_data_ready two clocks after req.
    cnt = '{1, 0, 0, 0};
    words[0][0] = 8'h5C;
    start_batch();
    @(negedge clk); #1;
    @(posedge clk); #1;
    check("lat_ack_load", int'(ack), 1);
    check("lat_ready_in_load", int'(tx_data_ready), 0);
    @(posedge clk); #1;
    check("lat_ready", int'(tx_data_ready), 1);
    check("lat_tx_data", int'(tx_data), 8'h5C);
    wait_ready(1'b0);
    check("sent_drops_ready", int'(tx_data_ready), 0);
    stray = 1'b1;
    check("gap1_busy", int'(busy), 1);
    @(posedge clk); #1;
    stray = 1'b0;
    check("gap2_busy", int'(busy), 1);
    check("gap_stray_no_ack", int'(ack), 0);
    @(posedge clk); #1;
    check("gap_end_idle", int'(busy), 0);
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    check("idle_stray_busy", int'(busy), 0);
    check("idle_stray_ack", int'(ack), 0);
    check("idle_stray_ready", int'(tx_data_ready), 0);
    wait_drain();

    // last_grant = 1, then requesters 0 and 3: 3 must win first.
    cnt = '{0, 1, 0, 0};
    words[1][0] = 8'($urandom_range(0, 255));
    start_batch();
    wait_drain();
    ack_log.delete();
    cnt = '{1, 0, 0, 1};
    words[0][0] = 8'($urandom_range(0, 255));
    words[3][0] = 8'($urandom_range(0, 255));
    start_batch();
    wait_drain();
    check("wrap_ack_count", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      check("wrap_first", ack_log[0], 3);
      check("wrap_second", ack_log[1], 0);
    end

    // Random batches of multi-word requests.
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] = int'($urandom_range(0, 3));
        for (int k = 0; k < 8; k++) words[i][k] = 8'($urandom_range(0, 255));
      end
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[$urandom_range(0, N - 1)] = 1;
      start_batch();
      wait_drain();
    end

    // Silent transmitter: abort after TIMEOUT SEND clocks.
    tx_mute = 1'b1;
    cnt = '{0, 0, 1, 0};
    words[2][0] = 8'($urandom_range(0, 255));
    start_batch();
    wait_ready(1'b1);
    n_send = tx_data_ready ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (!tx_data_ready) break;
      n_send++;
    end
    check("to_send_clocks", n_send, TIMEOUT);
    check("to_ready_low", int'(tx_data_ready), 0);
    check("to_err_pulse", int'(timeout_err), 1);
    @(posedge clk); #1;
    check("to_err_clear", int'(timeout_err), 0);
    tx_mute = 1'b0;
    wait_drain();

    // Reset in the middle of SEND.
    tx_mute = 1'b1;
    cnt = '{0, 1, 0, 0};
    words[1][0] = 8'($urandom_range(0, 255));
    start_batch();
    wait_ready(1'b1);
    check("mid_send_ready", int'(tx_data_ready), 1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", int'(tx_data_ready), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ack", int'(ack), 0);
    check("arst_tx_data", int'(tx_data), 0);
    check("arst_grant_id", int'(grant_id), 0);
    check("arst_timeout_err", int'(timeout_err), 0);
    model_last = N - 1;
    tx_mute = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_act = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || tx_data_ready) saw_act = 1'b1;
    end
    check("post_rst_no_resend", int'(saw_act), 0);

    // After reset requester 0 has first priority again.
    ack_log.delete();
    cnt = '{1, 1, 0, 0};
    words[0][0] = 8'($urandom_range(0, 255));
    words[1][0] = 8'($urandom_range(0, 255));
    start_batch();
    wait_drain();
    check("post_rst_ack_count", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      check("post_rst_first", ack_log[0], 0);
      check("post_rst_second", ack_log[1], 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
